// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains a single-clock FIFO into fixed-length packets on a
// valid/ready stream with sop/eop markers. A 2-entry buffer absorbs the FIFO's
// one-cycle read latency; a read is only issued when a buffer slot is certain.
module fifo_pkt_reader #(
    parameter int W     = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             fifo_read_o,
    input  logic [W-1:0]     fifo_data_i,
    input  logic             fifo_valid_i,
    input  logic             fifo_empty_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [W-1:0]     m_data_o,
    output logic             m_sop_o,
    output logic             m_eop_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_rd_q, rem_rd_d, rem_out_q, rem_out_d;
    logic             first_q, first_d;
    logic             inflight_q;
    logic             done_q, done_d, aborted_q, aborted_d;
    logic [1:0]       occ_q, occ_d;
    logic [W-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;   // buf0 is the head

    logic             run, pop, push, rd;
    logic [2:0]       credit;

    assign run       = (state_q == RUN);
    assign m_valid_o = (occ_q != 2'd0);
    assign pop       = m_valid_o && m_ready_i;
    // Abort discards the returning word along with the buffer contents.
    assign push      = run && fifo_valid_i && !abort_i;
    // Slots already spoken for after this cycle's pop; a pop frees one now.
    assign credit    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd        = run && !abort_i && !fifo_empty_i && (rem_rd_q != '0) && (credit < 3'd2);

    assign fifo_read_o = rd;
    assign m_data_o    = buf0_q;
    assign m_sop_o     = m_valid_o && first_q;
    assign m_eop_o     = m_valid_o && (rem_out_q == LEN_W'(1));
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;

    // Next-state: FSM transitions, packet counters and the 2-entry buffer.
    always_comb begin
        state_d   = state_q;
        rem_rd_d  = rem_rd_q;
        rem_out_d = rem_out_q;
        first_d   = first_q;
        occ_d     = occ_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && (len_i != '0)) begin
                    state_d   = RUN;
                    rem_rd_d  = len_i;
                    rem_out_d = len_i;
                    first_d   = 1'b1;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = FLUSH;
                    occ_d   = 2'd0;
                end else begin
                    if (rd)
                        rem_rd_d = rem_rd_q - LEN_W'(1);
                    if (pop) begin
                        rem_out_d = rem_out_q - LEN_W'(1);
                        first_d   = 1'b0;
                        if (m_eop_o) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    case ({push, pop})
                        2'b10: begin
                            if (occ_q == 2'd0) buf0_d = fifo_data_i;
                            else               buf1_d = fifo_data_i;
                            occ_d = occ_q + 2'd1;
                        end
                        2'b01: begin
                            buf0_d = buf1_q;
                            occ_d  = occ_q - 2'd1;
                        end
                        2'b11: begin
                            if (occ_q == 2'd1) begin
                                buf0_d = fifo_data_i;
                            end else begin
                                buf0_d = buf1_q;
                                buf1_d = fifo_data_i;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FLUSH: begin
                // One cycle lets a pre-abort read return and be dropped.
                state_d   = IDLE;
                aborted_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rem_rd_q   <= '0;
            rem_out_q  <= '0;
            first_q    <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_rd_q   <= rem_rd_d;
            rem_out_q  <= rem_out_d;
            first_q    <= first_d;
            inflight_q <= rd;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    // The read credit rule must never let a returning word find the buffer full.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: behavioural 1-cycle-latency FIFO, a per-cycle
// vector table for the basic packet, and scoreboarded multi-cycle scenarios.
module tb_fifo_pkt_reader;
    localparam int W = 16;
    localparam int LEN_W = 16;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             fifo_read, fifo_valid, fifo_empty, m_valid, m_sop, m_eop, busy, done, aborted;
    logic [W-1:0]     fifo_data, m_data;
    int               checks = 0, errors = 0;

    logic [W-1:0]     mem [0:255];
    int               wr_ptr = 0, rd_ptr = 0;

    fifo_pkt_reader #(.W(W), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .abort_i(abort),
        .fifo_read_o(fifo_read), .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid),
        .fifo_empty_i(fifo_empty), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_data_o(m_data), .m_sop_o(m_sop), .m_eop_o(m_eop), .busy_o(busy),
        .done_o(done), .aborted_o(aborted)
    );

    always #5 clk = ~clk;

    // FIFO model: data returns one cycle after an accepted read.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_valid <= 1'b0;
            fifo_data  <= '0;
        end else begin
            fifo_valid <= fifo_read;
            if (fifo_read) begin
                fifo_data <= mem[rd_ptr[7:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_pkt(input int n);
        @(negedge clk);
        start = 1'b1; len = LEN_W'(n); m_ready = 1'b1; abort = 1'b0;
        #1;
    endtask

    // Runs a started packet to completion with a scoreboard on the FIFO order.
    task automatic run_pkt(input string tag, input int n, input bit bp, input int late_at,
                           input int late_n, input int bstart_at,
                           output int first_cyc, output int done_cyc, output bit gap);
        int base, npop, ndone, occ;
        logic pv, pr, pp;
        logic [W-1:0] pd;
        base = rd_ptr; npop = 0; ndone = 0; occ = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; gap = 1'b0;
        first_cyc = -1; done_cyc = -1;
        for (int cyc = 1; cyc <= 200 && ndone == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == bstart_at);
            if (cyc == bstart_at) len = LEN_W'(5);
            m_ready = bp ? ((cyc % 3) == 1) : 1'b1;
            if (cyc == late_at)
                for (int k = 0; k < late_n; k++) push_word(W'(16'hC000 + k));
            #1;
            pp = m_valid && m_ready;
            if (pv && !pr) begin
                chk($sformatf("%s hold valid c%0d", tag, cyc), m_valid, 1);
                chk($sformatf("%s hold data c%0d", tag, cyc), m_data, pd);
            end
            if (pp) begin
                if (npop == 0) first_cyc = cyc;
                chk($sformatf("%s data #%0d", tag, npop), m_data, mem[8'(base + npop)]);
                chk($sformatf("%s sop #%0d", tag, npop), m_sop, (npop == 0));
                chk($sformatf("%s eop #%0d", tag, npop), m_eop, (npop == n - 1));
                npop++;
            end else if (occ + int'(fifo_valid) == 2) begin
                chk($sformatf("%s credit c%0d", tag, cyc), fifo_read, 0);
            end
            if (npop > 0 && npop < n && !m_valid) gap = 1'b1;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                chk($sformatf("%s pops at done", tag), npop, n);
            end
            occ = occ + int'(fifo_valid) - int'(pp);
            pv = m_valid; pr = m_ready; pd = m_data;
        end
        chk($sformatf("%s done seen", tag), ndone, 1);
        chk($sformatf("%s reads", tag), rd_ptr - base, n);
        @(negedge clk);
        start = 1'b0; m_ready = 1'b1;
        #1;
        chk($sformatf("%s done once", tag), done, 0);
        chk($sformatf("%s idle", tag), busy, 0);
    endtask

    typedef struct {
        logic         rdy;
        logic         rd;
        logic         vld;
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
        logic         dn;
        logic         bsy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int fc, dc, base;
        bit gp;
        // Basic packet, cycles 1..8 after start is accepted at edge 0.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values.
        #1;
        chk("rst fifo_read", fifo_read, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data", m_data, 0);
        chk("rst sop/eop", {m_sop, m_eop}, 0);
        chk("rst busy/done/aborted", {busy, done, aborted}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic packet, table driven.
        for (int k = 1; k <= 4; k++) push_word(W'(k));
        start_pkt(4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0; m_ready = tbl[i].rdy;
            #1;
            chk($sformatf("basic c%0d fifo_read", i + 1), fifo_read, tbl[i].rd);
            chk($sformatf("basic c%0d m_valid", i + 1), m_valid, tbl[i].vld);
            if (tbl[i].vld)
                chk($sformatf("basic c%0d m_data", i + 1), m_data, tbl[i].data);
            chk($sformatf("basic c%0d sop", i + 1), m_sop, tbl[i].sop);
            chk($sformatf("basic c%0d eop", i + 1), m_eop, tbl[i].eop);
            chk($sformatf("basic c%0d done", i + 1), done, tbl[i].dn);
            chk($sformatf("basic c%0d busy", i + 1), busy, tbl[i].bsy);
        end
        chk("basic reads", rd_ptr, 4);

        // Backpressure with ready pattern 1,0,0.
        for (int k = 0; k < 8; k++) push_word(W'(16'h0010 + k));
        start_pkt(8);
        run_pkt("bp", 8, 1'b1, 0, 0, 0, fc, dc, gp);

        // Underflow: 3 words now, 3 more later.
        for (int k = 0; k < 3; k++) push_word(W'(16'h0020 + k));
        start_pkt(6);
        run_pkt("uflow", 6, 1'b0, 13, 3, 0, fc, dc, gp);
        chk("uflow gap", gp, 1);

        // Abort with a read in flight.
        for (int k = 0; k < 12; k++) push_word(W'(16'h0030 + k));
        base = rd_ptr;
        start_pkt(10);
        @(negedge clk); start = 1'b0; #1;
        chk("abort c1 read", fifo_read, 1);
        @(negedge clk); abort = 1'b1; #1;
        chk("abort c2 read forced", fifo_read, 0);
        @(negedge clk); abort = 1'b0; #1;
        chk("abort flush busy", busy, 1);
        chk("abort flush m_valid", m_valid, 0);
        chk("abort flush read", fifo_read, 0);
        chk("abort flush aborted", aborted, 0);
        @(negedge clk); #1;
        chk("abort pulse", aborted, 1);
        chk("abort idle", busy, 0);
        chk("abort m_valid", m_valid, 0);
        @(negedge clk); #1;
        chk("abort pulse once", aborted, 0);
        chk("abort reads lost", rd_ptr - base, 1);
        start_pkt(2);
        run_pkt("post-abort", 2, 1'b0, 0, 0, 0, fc, dc, gp);

        // Ignored start with len=0.
        base = rd_ptr;
        start_pkt(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 1'b0; #1;
            chk($sformatf("len0 c%0d busy", i + 1), busy, 0);
            chk($sformatf("len0 c%0d read", i + 1), fifo_read, 0);
            chk($sformatf("len0 c%0d done", i + 1), done, 0);
        end
        chk("len0 reads", rd_ptr - base, 0);

        // Start while busy is ignored.
        start_pkt(2);
        run_pkt("busy-start", 2, 1'b0, 0, 0, 2, fc, dc, gp);

        // Async reset mid-packet with m_valid high.
        start_pkt(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 1'b0; #1;
        end
        chk("pre-rst m_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst fifo_read", fifo_read, 0);
        chk("arst m_valid", m_valid, 0);
        chk("arst m_data", m_data, 0);
        chk("arst sop/eop", {m_sop, m_eop}, 0);
        chk("arst busy/done/aborted", {busy, done, aborted}, 0);
        @(negedge clk); rst_n = 1'b1;
        start_pkt(4);
        run_pkt("fresh", 4, 1'b0, 0, 0, 0, fc, dc, gp);
        chk("fresh first beat cycle", fc, 3);
        chk("fresh done cycle", dc, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
